// File: rtl/hazard_stall_unit_if.sv
// Hazard unit bundle: ID/EX status into the interlock, stall/flush controls back to the pipeline.
// Latency: none (wires only). Backpressure: PC_write/IFID_write/EX_hold are the pipeline's stall controls.
interface hazard_stall_unit_if #(
  parameter int REG_ADDR_W = 5
);
  logic [REG_ADDR_W-1:0] IFID_rs1;
  logic [REG_ADDR_W-1:0] IFID_rs2;
  logic                  IFID_uses_rs2;
  logic [REG_ADDR_W-1:0] IDEX_rd;
  logic                  IDEX_MemRead;
  logic                  IDEX_is_div;
  logic                  EX_branch_taken;
  logic                  PC_write;
  logic                  IFID_write;
  logic                  IFID_flush;
  logic                  IDEX_bubble;
  logic                  EX_hold;
  logic [31:0]           stall_count;

  // Pipeline side: supplies stage status, obeys the stall/flush controls.
  modport master (
    output IFID_rs1, IFID_rs2, IFID_uses_rs2, IDEX_rd, IDEX_MemRead,
           IDEX_is_div, EX_branch_taken,
    input  PC_write, IFID_write, IFID_flush, IDEX_bubble, EX_hold, stall_count
  );

  // Interlock side.
  modport slave (
    input  IFID_rs1, IFID_rs2, IFID_uses_rs2, IDEX_rd, IDEX_MemRead,
           IDEX_is_div, EX_branch_taken,
    output PC_write, IFID_write, IFID_flush, IDEX_bubble, EX_hold, stall_count
  );
endinterface

// File: rtl/hazard_stall_unit.sv
// Pipeline interlock: load-use stall, multi-cycle divide hold, taken-branch flush. Optional HAZARD_PERF_EN stall counter.
// Latency: controls are combinational from state + inputs in the same cycle; divide hold lasts DIV_LATENCY-1 cycles.
// Backpressure: stalls upstream via PC_write/IFID_write=0 and freezes EX via EX_hold; never stalls on its own.
module hazard_stall_unit #(
  parameter int REG_ADDR_W  = 5,
  parameter int DIV_LATENCY = 34
) (
  input  logic               clk,
  input  logic               rst,
  hazard_stall_unit_if.slave hz
);

  typedef enum logic {
    IDLE     = 1'b0,
    DIV_BUSY = 1'b1
  } state_t;

  localparam logic [7:0] CNT_INIT = 8'(DIV_LATENCY - 2);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] cnt;
  logic [7:0] cnt_nxt;
  logic       div_seen;
  logic       load_use;
  logic       rd_is_x0;
  logic       rs1_hit;
  logic       rs2_hit;

  logic       pc_write;
  logic       ifid_write;
  logic       ifid_flush;
  logic       idex_bubble;
  logic       ex_hold;

  assign rd_is_x0 = (hz.IDEX_rd == REG_ADDR_W'(0));
  assign rs1_hit  = (hz.IDEX_rd == hz.IFID_rs1);
  assign rs2_hit  = hz.IFID_uses_rs2 && (hz.IDEX_rd == hz.IFID_rs2);
  assign load_use = hz.IDEX_MemRead && !rd_is_x0 && (rs1_hit || rs2_hit);

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    ex_hold     = 1'b0;

    case (state)
      IDLE: begin
        // div_seen masks the still-present divide the cycle after a 2-cycle divide held EX.
        if (hz.IDEX_is_div && !div_seen) begin
          ex_hold    = 1'b1;
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          cnt_nxt    = CNT_INIT;
          if (DIV_LATENCY > 2) begin
            state_nxt = DIV_BUSY;
          end
        end else if (hz.EX_branch_taken) begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
        end else if (load_use) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
        end
      end

      DIV_BUSY: begin
        if (cnt != 8'd0) begin
          ex_hold    = 1'b1;
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          cnt_nxt    = cnt - 8'd1;
        end else begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 8'd0;
      div_seen <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      div_seen <= ex_hold;
    end
  end

  // Reset overrides the controls so the pipeline sees a free-running, unflushed state.
  assign hz.PC_write    = rst | pc_write;
  assign hz.IFID_write  = rst | ifid_write;
  assign hz.IFID_flush  = !rst & ifid_flush;
  assign hz.IDEX_bubble = !rst & idex_bubble;
  assign hz.EX_hold     = !rst & ex_hold;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= 32'd0;
    end else if (!hz.PC_write && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign hz.stall_count = stall_cnt;
`else
  assign hz.stall_count = 32'd0;
`endif

  a_bubble_hold_excl: assert property (@(posedge clk) disable iff (rst) !(hz.IDEX_bubble && hz.EX_hold));

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: DIV_LATENCY=34 instance for the main scenarios, DIV_LATENCY=2 for back-to-back divides.
module tb_hazard_stall_unit;

  // Output vector order: {PC_write, IFID_write, IFID_flush, IDEX_bubble, EX_hold}
  localparam logic [4:0] IDLE_V = 5'b11000;
  localparam logic [4:0] LU_V   = 5'b00010;
  localparam logic [4:0] BR_V   = 5'b11110;
  localparam logic [4:0] HOLD_V = 5'b00001;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  hazard_stall_unit_if #(.REG_ADDR_W(5)) hz_if ();
  hazard_stall_unit_if #(.REG_ADDR_W(5)) hz2_if ();

  hazard_stall_unit #(.REG_ADDR_W(5), .DIV_LATENCY(34)) u_dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz_if)
  );

  hazard_stall_unit #(.REG_ADDR_W(5), .DIV_LATENCY(2)) u_dut2 (
    .clk (clk),
    .rst (rst),
    .hz  (hz2_if)
  );

  logic [4:0] obs;
  logic [4:0] obs2;
  assign obs  = {hz_if.PC_write, hz_if.IFID_write, hz_if.IFID_flush, hz_if.IDEX_bubble, hz_if.EX_hold};
  assign obs2 = {hz2_if.PC_write, hz2_if.IFID_write, hz2_if.IFID_flush, hz2_if.IDEX_bubble, hz2_if.EX_hold};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic uses_rs2,
                        input logic [4:0] rd, input logic mem_read, input logic is_div,
                        input logic br);
    hz_if.IFID_rs1        = rs1;
    hz_if.IFID_rs2        = rs2;
    hz_if.IFID_uses_rs2   = uses_rs2;
    hz_if.IDEX_rd         = rd;
    hz_if.IDEX_MemRead    = mem_read;
    hz_if.IDEX_is_div     = is_div;
    hz_if.EX_branch_taken = br;
  endtask

  task automatic test_reset();
    // Inputs that would stall and divide: reset must still force idle controls.
    set_in(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if (obs !== IDLE_V) begin
      fails++;
      $display("FAIL reset_outputs: got %b want %b", obs, IDLE_V);
    end
    tests++;
    if (hz_if.stall_count !== 32'd0) begin
      fails++;
      $display("FAIL reset_stall_count: got %0d want 0", hz_if.stall_count);
    end
    next_cycle();
    rst = 1'b0;
    set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    tests++;
    if (obs !== IDLE_V) begin
      fails++;
      $display("FAIL idle_after_reset: got %b want %b", obs, IDLE_V);
    end
    next_cycle();
  endtask

  task automatic test_load_use();
    // lw x5 in EX, ID reads x5 through rs1
    set_in(5'd5, 5'd9, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    tests++;
    if (obs !== LU_V) begin
      fails++;
      $display("FAIL load_use_rs1: got %b want %b", obs, LU_V);
    end
    next_cycle();
    // bubble now occupies EX
    set_in(5'd5, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    tests++;
    if (obs !== IDLE_V) begin
      fails++;
      $display("FAIL load_use_release: got %b want %b", obs, IDLE_V);
    end
    next_cycle();
    // match through rs2 on an R-type
    set_in(5'd3, 5'd12, 1'b1, 5'd12, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    tests++;
    if (obs !== LU_V) begin
      fails++;
      $display("FAIL load_use_rs2: got %b want %b", obs, LU_V);
    end
    next_cycle();
  endtask

  task automatic test_no_stall();
    set_in(5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    tests++;
    if (obs !== IDLE_V) begin
      fails++;
      $display("FAIL no_stall_x0: got %b want %b", obs, IDLE_V);
    end
    next_cycle();
    set_in(5'd3, 5'd5, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    tests++;
    if (obs !== IDLE_V) begin
      fails++;
      $display("FAIL no_stall_rs2_unused: got %b want %b", obs, IDLE_V);
    end
    next_cycle();
    set_in(5'd5, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    tests++;
    if (obs !== IDLE_V) begin
      fails++;
      $display("FAIL no_stall_not_load: got %b want %b", obs, IDLE_V);
    end
    next_cycle();
  endtask

  task automatic test_branch();
    set_in(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    tests++;
    if (obs !== BR_V) begin
      fails++;
      $display("FAIL branch_over_load_use: got %b want %b", obs, BR_V);
    end
    next_cycle();
    set_in(5'd1, 5'd2, 1'b1, 5'd7, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    tests++;
    if (obs !== BR_V) begin
      fails++;
      $display("FAIL branch_alone: got %b want %b", obs, BR_V);
    end
    next_cycle();
    set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Holds is_div for the divide's full 34-cycle EX occupancy; optionally injects a branch + load-use mid-divide.
  task automatic run_divide(input string tag, input bit inject);
    int          holds;
    logic [4:0]  exp_v;
    logic [31:0] sc0;
    logic [31:0] exp_sc;
    holds = 0;
    sc0   = hz_if.stall_count;
    for (int i = 0; i < 34; i++) begin
      if (inject && (i == 5))
        set_in(5'd7, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b1);
      else
        set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      exp_v = (i < 33) ? HOLD_V : IDLE_V;
      tests++;
      if (obs !== exp_v) begin
        fails++;
        $display("FAIL %s_cycle%0d: got %b want %b", tag, i, obs, exp_v);
      end
      if (obs === HOLD_V) holds++;
      next_cycle();
    end
    tests++;
    if (holds != 33) begin
      fails++;
      $display("FAIL %s_hold_len: got %0d want 33", tag, holds);
    end
`ifdef HAZARD_PERF_EN
    exp_sc = sc0 + 32'd33;
`else
    exp_sc = 32'd0;
`endif
    tests++;
    if (hz_if.stall_count !== exp_sc) begin
      fails++;
      $display("FAIL %s_stall_count: got %0d want %0d", tag, hz_if.stall_count, exp_sc);
    end
    set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    tests++;
    if (obs !== IDLE_V) begin
      fails++;
      $display("FAIL %s_after: got %b want %b", tag, obs, IDLE_V);
    end
    next_cycle();
  endtask

  task automatic test_div();
    run_divide("div", 1'b1);
  endtask

  task automatic test_reset_mid_div();
    set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tests++;
      if (obs !== HOLD_V) begin
        fails++;
        $display("FAIL rstdiv_pre_cycle%0d: got %b want %b", i, obs, HOLD_V);
      end
      next_cycle();
    end
    rst = 1'b1;
    #1;
    tests++;
    if (obs !== IDLE_V) begin
      fails++;
      $display("FAIL rstdiv_immediate: got %b want %b", obs, IDLE_V);
    end
    tests++;
    if (hz_if.stall_count !== 32'd0) begin
      fails++;
      $display("FAIL rstdiv_stall_count: got %0d want 0", hz_if.stall_count);
    end
    next_cycle();
    rst = 1'b0;
    run_divide("rstdiv_new", 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [4:0] exp_v;
    hz2_if.IDEX_is_div = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      exp_v = (i % 2 == 0) ? HOLD_V : IDLE_V;
      tests++;
      if (obs2 !== exp_v) begin
        fails++;
        $display("FAIL b2b_cycle%0d: got %b want %b", i, obs2, exp_v);
      end
      next_cycle();
    end
    hz2_if.IDEX_is_div = 1'b0;
    @(negedge clk);
    tests++;
    if (obs2 !== IDLE_V) begin
      fails++;
      $display("FAIL b2b_after: got %b want %b", obs2, IDLE_V);
    end
    next_cycle();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst   = 1'b1;
    set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    hz2_if.IFID_rs1        = 5'd0;
    hz2_if.IFID_rs2        = 5'd0;
    hz2_if.IFID_uses_rs2   = 1'b0;
    hz2_if.IDEX_rd         = 5'd0;
    hz2_if.IDEX_MemRead    = 1'b0;
    hz2_if.IDEX_is_div     = 1'b0;
    hz2_if.EX_branch_taken = 1'b0;
    next_cycle();

    test_reset();
    test_load_use();
    test_no_stall();
    test_branch();
    test_div();
    test_reset_mid_div();
    test_back_to_back();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
